// File: rtl/paced_counter.sv
// Rate-paced up/down modulo counter: fractional prescaler, step control, load, wrap/saturate.
// Optional registered BCD output is enabled by defining PACED_COUNTER_BCD_OUT_EN.
module paced_counter #(
  parameter int COUNT_WIDTH  = 16,
  parameter int MAX_VAL      = 20,
  parameter int STEP_WIDTH   = 10,
  parameter int MAX_STEP     = 1023,
  parameter int DEFAULT_STEP = 1,
  parameter int DELAY        = 100000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   step_inc,
  input  logic                   dir,
  input  logic                   sat_mode,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  output logic [STEP_WIDTH-1:0]  step,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tick,
  output logic                   updated,
  output logic                   wrapped
`ifdef PACED_COUNTER_BCD_OUT_EN
 ,output logic [15:0]            bcd
`endif
);

  localparam int AW = $clog2(DELAY) + 1;
  localparam logic [AW-1:0]          DLY = AW'(DELAY);
  localparam logic [COUNT_WIDTH-1:0] TOP = COUNT_WIDTH'(MAX_VAL - 1);

  logic [AW-1:0]          acc, sum;
  logic                   ovf, at_top, at_bot;
  logic [COUNT_WIDTH-1:0] ld_val;

  // acc and step are both below DELAY, so the sum never exceeds AW bits
  assign sum    = acc + AW'(step);
  assign ovf    = (sum >= DLY);
  assign at_top = (count == TOP);
  assign at_bot = (count == '0);
  // widened compare so MAX_VAL == 2**COUNT_WIDTH stays representable
  assign ld_val = ({1'b0, load_val} >= (COUNT_WIDTH+1)'(MAX_VAL)) ? TOP : load_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      step <= STEP_WIDTH'(DEFAULT_STEP);
    else if (step_inc)
      step <= (step == STEP_WIDTH'(MAX_STEP)) ? STEP_WIDTH'(1) : step + STEP_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      count   <= '0;
      tick    <= 1'b0;
      updated <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      tick    <= 1'b0;
      updated <= 1'b0;
      wrapped <= 1'b0;
      if (load) begin
        acc     <= '0;
        count   <= ld_val;
        updated <= 1'b1;
      end else if (en) begin
        acc  <= ovf ? sum - DLY : sum;
        tick <= ovf;
        if (ovf) begin
          if (dir) begin
            if (!at_top) begin
              count   <= count + COUNT_WIDTH'(1);
              updated <= 1'b1;
            end else if (!sat_mode) begin
              count   <= '0;
              updated <= 1'b1;
              wrapped <= 1'b1;
            end
          end else begin
            if (!at_bot) begin
              count   <= count - COUNT_WIDTH'(1);
              updated <= 1'b1;
            end else if (!sat_mode) begin
              count   <= TOP;
              updated <= 1'b1;
              wrapped <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef PACED_COUNTER_BCD_OUT_EN
  logic [13:0] bval;
  logic [29:0] sh;

  // double-dabble on a value clamped to 9999, which always fits 14 bits
  always_comb begin
    bval = (32'(count) >= 32'd9999) ? 14'd9999 : 14'(count);
    sh   = {16'd0, bval};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++)
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      sh = sh << 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bcd <= '0;
    else      bcd <= sh[29:14];
  end
`endif

endmodule

// File: tb/tb_paced_counter.sv
// Randomised + directed bench for paced_counter against an arithmetic reference model.
module tb_paced_counter;
  localparam int CW = 16, SW = 10, MV = 5, MS = 7, DS = 1, DL = 10;

  logic          clk = 1'b0, rst = 1'b0;
  logic          en = 1'b0, step_inc = 1'b0, dir = 1'b1, sat_mode = 1'b0, load = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [SW-1:0] step;
  logic [CW-1:0] count;
  logic          tick, updated, wrapped;

  int n_chk = 0, n_pass = 0;
  int m_step, m_count, m_total, m_tick, m_upd, m_wrap, m_bcd;
  int n_tick, n_wrap, n_upd;

  always #5 clk = ~clk;

`ifdef PACED_COUNTER_BCD_OUT_EN
  logic [15:0]   bcd, bcd_b;
  logic          load_b = 1'b0;
  logic [CW-1:0] load_val_b = '0;
  logic [SW-1:0] step_b;
  logic [CW-1:0] count_b;
  logic          tick_b, updated_b, wrapped_b;
`endif

  paced_counter #(.COUNT_WIDTH(CW), .MAX_VAL(MV), .STEP_WIDTH(SW), .MAX_STEP(MS),
                  .DEFAULT_STEP(DS), .DELAY(DL)) dut (
    .clk(clk), .rst(rst), .en(en), .step_inc(step_inc), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .step(step), .count(count), .tick(tick),
    .updated(updated), .wrapped(wrapped)
`ifdef PACED_COUNTER_BCD_OUT_EN
   ,.bcd(bcd)
`endif
  );

`ifdef PACED_COUNTER_BCD_OUT_EN
  paced_counter #(.COUNT_WIDTH(CW), .MAX_VAL(20000), .STEP_WIDTH(SW), .MAX_STEP(MS),
                  .DEFAULT_STEP(DS), .DELAY(DL)) dut_b (
    .clk(clk), .rst(rst), .en(1'b0), .step_inc(1'b0), .dir(1'b1), .sat_mode(1'b0),
    .load(load_b), .load_val(load_val_b), .step(step_b), .count(count_b), .tick(tick_b),
    .updated(updated_b), .wrapped(wrapped_b), .bcd(bcd_b)
  );
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_step = DS; m_count = 0; m_total = 0; m_tick = 0; m_upd = 0; m_wrap = 0; m_bcd = 0;
  endtask

  // Tick when the running total of steps since reset/load crosses a multiple of DELAY.
  task automatic model_step();
    m_bcd = m_count;
    m_tick = 0; m_upd = 0; m_wrap = 0;
    if (load) begin
      m_count = (int'(load_val) >= MV) ? MV - 1 : int'(load_val);
      m_total = 0;
      m_upd   = 1;
    end else if (en) begin
      m_tick  = ((m_total + m_step) / DL != m_total / DL) ? 1 : 0;
      m_total = m_total + m_step;
      if (m_tick == 1) begin
        if (dir) begin
          if (m_count < MV - 1) begin m_count++; m_upd = 1; end
          else if (!sat_mode)   begin m_count = 0; m_upd = 1; m_wrap = 1; end
        end else begin
          if (m_count > 0)      begin m_count--; m_upd = 1; end
          else if (!sat_mode)   begin m_count = MV - 1; m_upd = 1; m_wrap = 1; end
        end
      end
    end
    if (step_inc) m_step = (m_step == MS) ? 1 : m_step + 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("tick", int'(tick), m_tick);
    chk("updated", int'(updated), m_upd);
    chk("wrapped", int'(wrapped), m_wrap);
    chk("count", int'(count), m_count);
    chk("step", int'(step), m_step);
`ifdef PACED_COUNTER_BCD_OUT_EN
    chk("bcd", int'(bcd), m_bcd);
`endif
    n_tick += int'(tick);
    n_wrap += int'(wrapped);
    n_upd  += int'(updated);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    en = 0; step_inc = 0; load = 0; dir = 1; sat_mode = 0; load_val = '0;
    @(negedge clk); rst = 0;
    model_reset();
    @(negedge clk); rst = 1;
  endtask

  // cycles until the next tick, -1 if none within the bound
  task automatic wait_tick(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      cycle();
      if (tick) begin k = i; break; end
    end
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_step", int'(step), DS);
    chk("rst_tick", int'(tick), 0);
    rst = 1;

    // 1: up/wrap
    do_reset();
    en = 1;
    n_tick = 0; n_wrap = 0;
    wait_tick(20, k);
    chk("first_tick_latency", k, 10);
    chk("count_after_1st", int'(count), 1);
    run(50 - k);
    chk("count_after_50", int'(count), 0);
    run(10);
    chk("ticks_60", n_tick, 6);
    chk("wraps_60", n_wrap, 1);

    // 2: step=3 pacing and step rollover
    do_reset();
    step_inc = 1; cycle(); cycle(); step_inc = 0;
    chk("step3", int'(step), 3);
    en = 1; n_tick = 0;
    run(30);
    chk("ticks_step3", n_tick, 9);
    en = 0; step_inc = 1;
    run(4);
    chk("step7", int'(step), 7);
    cycle();
    chk("step_roll", int'(step), 1);
    step_inc = 0;

    // 3: down saturate, then wrap
    do_reset();
    dir = 0; sat_mode = 1; en = 1; n_tick = 0; n_upd = 0;
    run(20);
    chk("sat_ticks", n_tick, 2);
    chk("sat_updates", n_upd, 0);
    chk("sat_count", int'(count), 0);
    sat_mode = 0;
    wait_tick(20, k);
    chk("down_wrap_count", int'(count), 4);
    chk("down_wrap_flag", int'(wrapped), 1);

    // 4: load colliding with a due overflow
    do_reset();
    en = 1;
    run(9);
    load = 1; load_val = 16'd9;
    cycle();
    load = 0;
    chk("load_clamp", int'(count), 4);
    chk("load_tick", int'(tick), 0);
    chk("load_upd", int'(updated), 1);
    wait_tick(30, k);
    chk("tick_after_load", k, 10);

    // 5: asynchronous reset mid-cycle
    do_reset();
    step_inc = 1; run(4); step_inc = 0;
    load = 1; load_val = 16'd3; cycle(); load = 0;
    chk("pre_rst_step", int'(step), 5);
    chk("pre_rst_count", int'(count), 3);
    #2 rst = 0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_step", int'(step), 1);
    chk("async_upd", int'(updated), 0);
    model_reset();
    @(negedge clk); rst = 1; en = 1;
    wait_tick(30, k);
    chk("tick_after_rst", k, 10);

`ifdef PACED_COUNTER_BCD_OUT_EN
    // 6: BCD conversion with a large modulus
    en = 0;
    load_b = 1; load_val_b = 16'd1234; cycle(); load_b = 0;
    chk("bcd_cnt", int'(count_b), 1234);
    chk("bcd_lag", int'(bcd_b), 0);
    cycle();
    chk("bcd_1234", int'(bcd_b), 16'h1234);
    load_b = 1; load_val_b = 16'd15000; cycle(); load_b = 0;
    cycle();
    chk("bcd_clamp", int'(bcd_b), 16'h9999);
`endif

    // random phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      step_inc = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = CW'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) sat_mode = ~sat_mode;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
